// File: rtl/bus_ready_ctrl.sv
// bus_ready_ctrl
// Programmable memory-map decoder and wait-state / READY generator for the
// TMS9900 breadboard system. N_REG regions are each decoded by a base/mask
// compare; the lowest matching index wins. Each region has its own wait-state
// count. Read data from the selected region is captured into a register when
// the access completes. An unmapped access, or one with rd and wr both high,
// completes with bus_err and ERR_DATA. The block also counts rising edges of
// the IAQ flag, which drives the activity LED.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   cpu_addr     CPU address (latched when a request is accepted)
//   cpu_rd       CPU read request
//   cpu_wr       CPU write request
//   cpu_iaq      instruction-acquisition flag
//   cpu_ready    one-cycle completion pulse to the CPU
//   cpu_data_in  registered read data to the CPU
//   mem_cs       one-hot region select
//   mem_we       one-hot region write enable
//   mem_rdata    packed per-region read data, region i at [i*DATA_W +: DATA_W]
//   bus_err      one-cycle pulse on an unmapped or illegal access
//   iaq_count    count of IAQ rising edges, wraps modulo 2^IAQ_W
module bus_ready_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int N_REG  = 4,
  parameter logic [N_REG*ADDR_W-1:0] REG_BASE = '0,
  parameter logic [N_REG*ADDR_W-1:0] REG_MASK = '0,
  parameter logic [N_REG*4-1:0]      REG_WAIT = '0,
  parameter logic [DATA_W-1:0]       ERR_DATA = {DATA_W{1'b1}},
  parameter int IAQ_W  = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic                    cpu_rd,
  input  logic                    cpu_wr,
  input  logic                    cpu_iaq,
  output logic                    cpu_ready,
  output logic [DATA_W-1:0]       cpu_data_in,
  output logic [N_REG-1:0]        mem_cs,
  output logic [N_REG-1:0]        mem_we,
  input  logic [N_REG*DATA_W-1:0] mem_rdata,
  output logic                    bus_err,
  output logic [IAQ_W-1:0]        iaq_count
);

  localparam int SEL_W = (N_REG > 1) ? $clog2(N_REG) : 1;

  // S_ERR exists so that an error completion appears one cycle after the
  // request is sampled, which matches the timing of a zero-wait access.
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR,
    S_DONE
  } state_t;

  state_t            state;
  logic [SEL_W-1:0]  sel;
  logic              op;
  logic [3:0]        cnt;
  logic              iaq_prev;

  logic              req;
  logic              hit;
  logic [SEL_W-1:0]  hit_idx;
  logic [N_REG-1:0]  hit_onehot;
  logic [3:0]        hit_wait;
  logic [DATA_W-1:0] sel_rdata;

  assign req = cpu_rd | cpu_wr;

  // Address decode. The scan runs from the highest index down so that a
  // lower-numbered match overwrites a higher one. This gives lowest-index
  // priority and guarantees that hit_onehot is never multi-hot.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    hit_onehot = '0;
    hit_wait   = '0;
    for (int i = N_REG - 1; i >= 0; i--) begin
      if ((cpu_addr & REG_MASK[i*ADDR_W +: ADDR_W]) == REG_BASE[i*ADDR_W +: ADDR_W]) begin
        hit        = 1'b1;
        hit_idx    = SEL_W'(i);
        hit_onehot = '0;
        hit_onehot[i] = 1'b1;
        hit_wait   = REG_WAIT[i*4 +: 4];
      end
    end
  end

  // Read-data mux driven by the latched region select. cpu_addr may change
  // during WAIT without affecting which region is captured.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_REG; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_rdata = mem_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Access FSM. cpu_ready and bus_err default low each cycle, so they can
  // only ever be single-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      sel         <= '0;
      op          <= 1'b0;
      cnt         <= '0;
      cpu_ready   <= 1'b0;
      bus_err     <= 1'b0;
      cpu_data_in <= '0;
      mem_cs      <= '0;
      mem_we      <= '0;
    end else begin
      cpu_ready <= 1'b0;
      bus_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            if ((cpu_rd && cpu_wr) || !hit) begin
              state <= S_ERR;
            end else begin
              sel    <= hit_idx;
              op     <= cpu_wr;
              cnt    <= hit_wait;
              mem_cs <= hit_onehot;
              mem_we <= cpu_wr ? hit_onehot : '0;
              state  <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!req) begin
            // The CPU abandoned the cycle, so no completion is signalled.
            mem_cs <= '0;
            mem_we <= '0;
            cnt    <= '0;
            state  <= S_IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            cpu_ready <= 1'b1;
            if (!op) begin
              cpu_data_in <= sel_rdata;
            end
            mem_cs <= '0;
            mem_we <= '0;
            state  <= S_DONE;
          end
        end
        S_ERR: begin
          cpu_ready   <= 1'b1;
          bus_err     <= 1'b1;
          cpu_data_in <= ERR_DATA;
          state       <= S_DONE;
        end
        S_DONE: begin
          // A held request must not retrigger; wait for rd/wr to drop.
          if (!req) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // IAQ rising-edge counter for the activity LED.
  always_ff @(posedge clk) begin
    if (reset) begin
      iaq_prev  <= 1'b0;
      iaq_count <= '0;
    end else begin
      iaq_prev <= cpu_iaq;
      if (cpu_iaq && !iaq_prev) begin
        iaq_count <= iaq_count + IAQ_W'(1);
      end
    end
  end

endmodule

// File: doc/bus_ready_ctrl.md
# bus_ready_ctrl

Parametrised memory-map decoder and wait-state/READY generator for the TMS9900 breadboard system. It replaces the fixed address-bit chip selects (RAM/ROM on A15, ACA on A15..A6) with N programmable regions. Each region has its own wait-state count and its own registered read-data capture. It sits between the CPU bus (addr, rd, wr, iaq, ready) and the on-chip ROM/SPRAM/peripheral blocks, and also provides the IAQ activity counter used for the status LED.

## Interface

Parameters:

- ADDR_W, 16, CPU address width.
- DATA_W, 16, data width.
- N_REG, 4, number of decode regions (1..8).
- REG_BASE, {N_REG{16'h0000}}, packed N_REG×ADDR_W base addresses; region i occupies bits [i*ADDR_W +: ADDR_W].
- REG_MASK, {N_REG{16'h0000}}, packed N_REG×ADDR_W compare masks.
- REG_WAIT, {N_REG{4'd0}}, packed N_REG×4 wait-state counts (0..15).
- ERR_DATA, 16'hFFFF, read data returned for an unmapped or illegal access.
- IAQ_W, 20, IAQ counter width.

Ports:

- clk, in, 1, system clock.
- reset, in, 1, synchronous, active-high.
- cpu_addr, in, ADDR_W, CPU address.
- cpu_rd, in, 1, CPU read request.
- cpu_wr, in, 1, CPU write request.
- cpu_iaq, in, 1, instruction-acquisition flag.
- cpu_ready, out, 1, one-cycle completion pulse to the CPU.
- cpu_data_in, out, DATA_W, registered read data to the CPU.
- mem_cs, out, N_REG, one-hot region select.
- mem_we, out, N_REG, one-hot write enable.
- mem_rdata, in, N_REG×DATA_W, packed per-region read data.
- bus_err, out, 1, one-cycle pulse on an unmapped or illegal access.
- iaq_count, out, IAQ_W, count of IAQ rising edges.

## Operation

- Decode: region i matches when (cpu_addr & MASK_i) == BASE_i. The lowest matching index wins. No match means unmapped.
- FSM states:
  - IDLE: transitions when req = cpu_rd | cpu_wr is sampled high.
    - cpu_rd & cpu_wr both high is illegal. Go to DONE with an error completion: cpu_ready=1, bus_err=1, cpu_data_in=ERR_DATA, no mem_cs asserted.
    - Unmapped access: same error completion as the illegal case.
    - Otherwise: latch sel=i and op=cpu_wr, load cnt=REG_WAIT_i, drive mem_cs[i]=1 and mem_we[i]=op, go to WAIT.
  - WAIT: cnt≠0 decrements cnt.
    - At cnt==0: cpu_ready=1; if op is read, cpu_data_in ← mem_rdata[sel]. Go to DONE.
    - If req drops while in WAIT (abort): go to IDLE, clear mem_cs/mem_we, no cpu_ready.
  - DONE: mem_cs and mem_we are cleared on entry. Stay in DONE until req is low, then go to IDLE.
- The address is latched at request start. Changes to cpu_addr during WAIT are ignored.
- cpu_data_in holds its value until the next read completion. Writes do not change it.
- IAQ counter: the previous cpu_iaq is registered. Each 0→1 edge increments iaq_count, which wraps modulo 2^IAQ_W.
- Reset, including mid-cycle: state=IDLE and cnt=0. cpu_ready, bus_err, mem_cs, mem_we, cpu_data_in and iaq_count are all 0, and the registered IAQ is 0.

## Timing

- E0 is the clock edge at which IDLE samples req high.
  - mem_cs and mem_we are high from E0 to E(W+1).
  - cpu_ready and captured data are visible from E(W+1) for exactly one cycle.
  - Read latency is W+1 cycles. With W=0 this suits single-cycle BRAM/SPRAM that is registered on mem_cs.
- Error completion: cpu_ready and bus_err go high at E1, one cycle after E0, for one cycle.
- A new access cannot start until one IDLE cycle after req falls.
  - Back-to-back requests with req held high do not retrigger.
  - The CPU must drop rd/wr between accesses.
- cpu_ready is never high for more than one consecutive cycle.
- mem_cs is never multi-hot.

## Test plan

- N_REG=2: ROM base 0000, mask 8000, W=0; RAM base 8000, mask 8000, W=2. Read 0x0010 with mem_rdata[0]=0x1234 → mem_cs=01 E0..E1, cpu_ready at E1, cpu_data_in=0x1234.
- Write 0x8002 on the same map → mem_cs=10 and mem_we=10 for exactly 3 cycles, cpu_ready at E3, cpu_data_in unchanged.
- Map with region 1 base FF00, mask FF00, and region 0 mask 0000 (matches everything); read 0xFF40 → region 0 selected (lowest index wins).
- Unmapped read (all masks FF00, no base match), and a separate access with cpu_rd=cpu_wr=1 → bus_err and cpu_ready pulse at E1, cpu_data_in=FFFF, mem_cs=0.
- Abort and reset: W=5, drop cpu_rd at E2 → no cpu_ready, mem_cs=0 next cycle. Repeat with reset asserted at E3 instead → all outputs 0 next cycle, FSM back to IDLE.
- IAQ counter: IAQ_W=4, 17 IAQ pulses → iaq_count=1 (wrap). IAQ held high for 10 cycles counts once.
